// File: rtl/aq_dcache_dirty_ctrl_if.sv
// aq_dcache_dirty_ctrl_if: pipeline, write-back and dirty-array signals of the dirty controller
interface aq_dcache_dirty_ctrl_if #(parameter int DW = 8);
  logic          wr_req;
  logic [13:0]   wr_idx;
  logic [DW-1:0] wr_din;
  logic [DW-1:0] wr_mask;
  logic          wr_gnt;
  logic          rd_req;
  logic [13:0]   rd_idx;
  logic          rd_gnt;
  logic          rd_dout_vld;
  logic [DW-1:0] rd_dout;
  logic          flush_req;
  logic          flush_busy;
  logic          flush_done;
  logic          wb_req;
  logic [13:0]   wb_idx;
  logic [DW-1:0] wb_dirty;
  logic          wb_ack;
  logic          dirty_cen;
  logic          dirty_gwen;
  logic [DW-1:0] dirty_wen;
  logic [DW-1:0] dirty_din;
  logic [13:0]   dirty_idx;
  logic          dirty_clk_en;
  logic [DW-1:0] dirty_dout;
  modport slave (
    input  wr_req, wr_idx, wr_din, wr_mask, rd_req, rd_idx, flush_req, wb_ack, dirty_dout,
    output wr_gnt, rd_gnt, rd_dout_vld, rd_dout, flush_busy, flush_done, wb_req, wb_idx,
           wb_dirty, dirty_cen, dirty_gwen, dirty_wen, dirty_din, dirty_idx, dirty_clk_en
  );
  modport master (
    output wr_req, wr_idx, wr_din, wr_mask, rd_req, rd_idx, flush_req, wb_ack, dirty_dout,
    input  wr_gnt, rd_gnt, rd_dout_vld, rd_dout, flush_busy, flush_done, wb_req, wb_idx,
           wb_dirty, dirty_cen, dirty_gwen, dirty_wen, dirty_din, dirty_idx, dirty_clk_en
  );
endinterface

// File: rtl/aq_dcache_dirty_ctrl.sv
// aq_dcache_dirty_ctrl: arbitrates the dirty array among pipeline write, pipeline read and a flush walker
module aq_dcache_dirty_ctrl #(
  parameter int SET_NUM = 128,
  parameter int SET_W   = 7,
  parameter int DW      = 8
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  aq_dcache_dirty_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, CHK, WB, CLR, DONE} state_t;
  state_t           state, state_nxt;
  logic [SET_W-1:0] set_cnt;
  logic [DW-1:0]    cap;
  logic             rd_vld;
  logic [13:0]      set_addr;
  logic             hit, walk_rd, walk_clr, last, adv;
  assign set_addr = 14'({set_cnt, 6'b0});
  // a write to the set being checked/written back/cleared must wait until the walker moves on
  assign hit      = (state == CHK || state == WB || state == CLR) && bus.wr_idx[SET_W+5:6] == set_cnt;
  assign bus.wr_gnt = bus.wr_req && !hit;
  assign bus.rd_gnt = bus.rd_req && !bus.wr_gnt;
  assign walk_rd  = state == RD && !bus.wr_req && !bus.rd_req;
  assign walk_clr = state == CLR && !bus.wr_gnt && !bus.rd_req;
  assign last     = set_cnt == SET_W'(SET_NUM - 1);
  assign adv      = (state == CHK && ~|bus.dirty_dout) || walk_clr;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.flush_req ? RD : IDLE;
      RD:      state_nxt = walk_rd ? CHK : RD;
      CHK:     state_nxt = |bus.dirty_dout ? WB : last ? DONE : RD;
      WB:      state_nxt = bus.wb_ack ? CLR : WB;
      CLR:     state_nxt = !walk_clr ? CLR : last ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= IDLE;
      set_cnt <= '0;
      cap     <= '0;
      rd_vld  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= bus.rd_gnt;
      if (state == IDLE && bus.flush_req) set_cnt <= '0;
      else if (adv && !last) set_cnt <= set_cnt + 1'b1;
      if (state == CHK) cap <= bus.dirty_dout;
    end
  end
  assign bus.rd_dout_vld  = rd_vld;
  assign bus.rd_dout      = bus.dirty_dout;
  assign bus.flush_busy   = state != IDLE;
  assign bus.flush_done   = state == DONE;
  assign bus.wb_req       = state == WB;
  assign bus.wb_idx       = set_addr;
  assign bus.wb_dirty     = cap;
  assign bus.dirty_cen    = !(bus.wr_gnt || bus.rd_gnt || walk_rd || walk_clr);
  assign bus.dirty_gwen   = !(bus.wr_gnt || walk_clr);
  assign bus.dirty_wen    = bus.wr_gnt ? ~bus.wr_mask : walk_clr ? ~cap : '1;
  assign bus.dirty_din    = bus.wr_gnt ? bus.wr_din : '0;
  assign bus.dirty_idx    = bus.wr_gnt ? bus.wr_idx : bus.rd_gnt ? bus.rd_idx :
                            (walk_rd || walk_clr) ? set_addr : '0;
  // keep the array clocked through the cycle its read data is consumed
  assign bus.dirty_clk_en = !bus.dirty_cen || rd_vld;
endmodule
